cpu_clk_ctrl: RTL and testbench

CPU clock-enable scheduler for the MIPS core on the FPGA board. It turns the board clock into a single `cpu_en_o` enable that the datapath uses as its clock enable. Five run modes are supported: halt, free-run, divided slow-run, button single-step, and a counted burst. An internal tick generator replaces the free-standing divider. Divider reload is glitch-free, and the block counts issued CPU cycles for the debug display.

---
 rtl/cpu_clk_pkg.sv | 35 +++
 rtl/cpu_clk_ctrl_tick_gen.sv | 36 +++
 rtl/cpu_clk_ctrl.sv | 119 +++++++++++
 tb/tb_cpu_clk_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared types for the CPU clock-enable scheduler: run-mode and FSM state encodings.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_clk_pkg;

   // Encoding of the mode_i selector input.
   typedef enum logic [1:0] {
      MODE_HALT = 2'd0,
      MODE_FREE = 2'd1,
      MODE_SLOW = 2'd2,
      MODE_STEP = 2'd3
   } mode_e;

   // Scheduler state; the encoding is driven straight onto the LED port.
   typedef enum logic [2:0] {
      ST_HALT  = 3'd0,
      ST_FREE  = 3'd1,
      ST_SLOW  = 3'd2,
      ST_STEP  = 3'd3,
      ST_BURST = 3'd4
   } state_e;

   // State selected by the mode input when no burst is active.
   function automatic state_e mode_to_state(input logic [1:0] m);
      state_e s;
      case (m)
         MODE_FREE: s = ST_FREE;
         MODE_SLOW: s = ST_SLOW;
         MODE_STEP: s = ST_STEP;
         default:   s = ST_HALT;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/cpu_clk_ctrl_tick_gen.sv
// Tick generator: one-cycle tick every (shadow max + 1) cycles, glitch-free reload.
// Latency: tick is combinational from the counter registers; clear takes effect next cycle.
// Backpressure: none.
// Ports: clk, rst (async, active-high), clear (zero counter + reload shadow),
//        max (requested period minus one), tick (counter has reached shadow max).
module tick_gen #(
   parameter int N = 28
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic [N-1:0] max,
   output logic         tick
);

   logic [N-1:0] cnt;
   logic [N-1:0] shadow;

   // >= rather than == so a counter that somehow exceeds the shadow still wraps.
   assign tick = (cnt >= shadow);

   // The shadow only follows max at a period boundary (wrap or clear), so a
   // mid-period change of max never alters the period already running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         shadow <= '0;
      end else if (clear || tick) begin
         cnt    <= '0;
         shadow <= max;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable scheduler: HALT / FREE / SLOW / STEP / counted BURST modes.
// Latency: mode change seen at edge k -> cpu_en_o from edge k+1; step press -> pulse 3 edges later.
// Backpressure: none; burst requests during a burst or with zero length are dropped.
// Ports: clk, rst (async, active-high), mode_i, div_max_i, step_i (async button),
//        burst_len_i, burst_start_i -> cpu_en_o, busy_o, state_o, cyc_count_o (all registered).
module cpu_clk_ctrl
   import cpu_clk_pkg::*;
#(
   parameter int N       = 28,
   parameter int BURST_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode_i,
   input  logic [N-1:0]       div_max_i,
   input  logic               step_i,
   input  logic [BURST_W-1:0] burst_len_i,
   input  logic               burst_start_i,
   output logic               cpu_en_o,
   output logic               busy_o,
   output logic [2:0]         state_o,
   output logic [31:0]        cyc_count_o
);

   state_e             state;
   state_e             state_nxt;
   logic [BURST_W-1:0] remain;
   logic [BURST_W-1:0] remain_nxt;
   logic               en_nxt;
   logic               burst_go;
   logic               tick_clear;
   logic               tick;
   logic               step_s1;
   logic               step_s2;
   logic               step_prev;
   logic               step_rise;
   logic [31:0]        cyc_cnt;

   tick_gen #(.N(N)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (tick_clear),
      .max   (div_max_i),
      .tick  (tick)
   );

   // Two-flop synchronizer, then a registered rising-edge detect so the
   // pulse is exactly one cycle wide no matter how long the button is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_s1   <= 1'b0;
         step_s2   <= 1'b0;
         step_prev <= 1'b0;
         step_rise <= 1'b0;
      end else begin
         step_s1   <= step_i;
         step_s2   <= step_s1;
         step_prev <= step_s2;
         step_rise <= step_s2 & ~step_prev;
      end
   end

   assign burst_go = burst_start_i && (burst_len_i != '0) && (state != ST_BURST);

   always_comb begin
      state_nxt  = mode_to_state(mode_i);
      remain_nxt = remain;
      en_nxt     = 1'b0;
      case (state)
         ST_FREE: en_nxt = 1'b1;
         ST_SLOW: en_nxt = tick;
         // Edges that arrive in any other state are simply never consumed.
         ST_STEP: en_nxt = step_rise;
         ST_BURST: begin
            state_nxt = ST_BURST;
            if (remain == '0) begin
               // Last pulse has gone out; hand control back to mode_i.
               state_nxt = mode_to_state(mode_i);
            end else if (tick) begin
               en_nxt     = 1'b1;
               remain_nxt = remain - 1'b1;
            end
         end
         default: en_nxt = 1'b0;
      endcase
      // A burst request overrides whatever mode_i asked for this cycle.
      if (burst_go) begin
         state_nxt  = ST_BURST;
         remain_nxt = burst_len_i;
      end
      // Restart the divider on every entry into a tick-paced state.
      tick_clear = ((state_nxt == ST_SLOW) || (state_nxt == ST_BURST)) && (state_nxt != state);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_HALT;
         remain   <= '0;
         cpu_en_o <= 1'b0;
      end else begin
         state    <= state_nxt;
         remain   <= remain_nxt;
         cpu_en_o <= en_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt <= '0;
      end else if (cpu_en_o) begin
         cyc_cnt <= cyc_cnt + 32'd1;
      end
   end

   assign busy_o      = (state == ST_BURST);
   assign state_o     = state;
   assign cyc_count_o = cyc_cnt;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: expected pulse edges are computed arithmetically
// from the mode rules (period = max+1, step delay 3 edges, burst spacing) with random parameters.
module tb_cpu_clk_ctrl;

   localparam int N  = 28;
   localparam int BW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    mode = 2'd0;
   logic [N-1:0]  div_max = '0;
   logic          step = 1'b0;
   logic [BW-1:0] burst_len = '0;
   logic          burst_start = 1'b0;
   logic          cpu_en;
   logic          busy;
   logic [2:0]    state;
   logic [31:0]   cyc_count;

   int            checks = 0;
   int            passes = 0;
   int            edge_n = 0;
   int            pulses[$];
   int            exp_q[$];
   logic [31:0]   exp_cyc = 32'd0;

   cpu_clk_ctrl #(.N(N), .BURST_W(BW)) dut (
      .clk           (clk),
      .rst           (rst),
      .mode_i        (mode),
      .div_max_i     (div_max),
      .step_i        (step),
      .burst_len_i   (burst_len),
      .burst_start_i (burst_start),
      .cpu_en_o      (cpu_en),
      .busy_o        (busy),
      .state_o       (state),
      .cyc_count_o   (cyc_count)
   );

   always #5 clk = ~clk;

   // edge_n = index of the most recent rising edge; stable when read at negedge.
   always @(posedge clk) edge_n <= edge_n + 1;

   // Record the edge at which every observed enable pulse started.
   always @(negedge clk) if (!rst && cpu_en) pulses.push_back(edge_n);

   task automatic wait_edge(input int e);
      while (edge_n < e) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 2'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (cpu_en !== 1'b0 || busy !== 1'b0 || state !== 3'd0 || cyc_count !== 32'd0)
         $display("FAIL reset_values: en=%b busy=%b state=%0d cyc=%0d want 0/0/0/0", cpu_en, busy, state, cyc_count);
      else passes++;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (cpu_en !== 1'b0) $display("FAIL halt_en cycle %0d: got %b want 0", i, cpu_en);
         else passes++;
      end
      checks++;
      if (cyc_count !== 32'd0) $display("FAIL halt_cyc: got %0d want 0", cyc_count);
      else passes++;
      checks++;
      if (state !== 3'd0) $display("FAIL halt_state: got %0d want 0", state);
      else passes++;
      pulses.delete();
      exp_cyc = 32'd0;
   endtask

   task automatic test_slow();
      int e, d1, d2, p1, p2, p3, p4;
      pulses.delete(); exp_q.delete();
      d1 = $urandom_range(7, 3);
      d2 = $urandom_range(2, 0);
      mode = 2'd2; div_max = N'(d1); e = edge_n + 1;
      p1 = e + d1 + 1; p2 = p1 + d1 + 1; p3 = p2 + d2 + 1; p4 = p3 + d2 + 1;
      exp_q = '{p1, p2, p3, p4};
      wait_edge(p1);
      div_max = N'(d2);              // mid-period: must only affect the period after next wrap
      checks++;
      if (state !== 3'd2) $display("FAIL slow_state: got %0d want 2", state);
      else passes++;
      wait_edge(p4 + d2 - 1);
      mode = 2'd0;
      repeat (d1 + 4) @(negedge clk);
      checks++;
      if (pulses.size() != exp_q.size())
         $display("FAIL slow_count (d1=%0d d2=%0d): got %0d pulses want %0d", d1, d2, pulses.size(), exp_q.size());
      else passes++;
      for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
         checks++;
         if (pulses[i] != exp_q[i]) $display("FAIL slow_pulse%0d: got edge %0d want edge %0d", i, pulses[i], exp_q[i]);
         else passes++;
      end
      exp_cyc += 32'(exp_q.size());
      checks++;
      if (cyc_count !== exp_cyc) $display("FAIL slow_cyc: got %0d want %0d", cyc_count, exp_cyc);
      else passes++;
   endtask

   task automatic test_step();
      int s, hold;
      pulses.delete(); exp_q.delete();
      mode = 2'd3;
      repeat (4) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         hold = (k == 0) ? 50 : $urandom_range(12, 1);
         step = 1'b1; s = edge_n + 1;
         exp_q.push_back(s + 3);
         repeat (hold) @(negedge clk);
         step = 1'b0;
         repeat ($urandom_range(9, 4)) @(negedge clk);
      end
      // A press while halted must be dropped.
      mode = 2'd0;
      repeat (3) @(negedge clk);
      step = 1'b1;
      repeat (4) @(negedge clk);
      step = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (pulses.size() != exp_q.size())
         $display("FAIL step_count: got %0d pulses want %0d", pulses.size(), exp_q.size());
      else passes++;
      for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
         checks++;
         if (pulses[i] != exp_q[i]) $display("FAIL step_pulse%0d: got edge %0d want edge %0d", i, pulses[i], exp_q[i]);
         else passes++;
      end
      exp_cyc += 32'd3;
      checks++;
      if (cyc_count !== exp_cyc) $display("FAIL step_cyc: got %0d want %0d", cyc_count, exp_cyc);
      else passes++;
   endtask

   task automatic test_burst();
      int f, b, d, len, pl;
      pulses.delete(); exp_q.delete();
      d = $urandom_range(3, 0); len = $urandom_range(6, 2);
      mode = 2'd1; div_max = N'(d); f = edge_n + 1;
      repeat (5) @(negedge clk);
      burst_start = 1'b1; burst_len = BW'(len); b = edge_n + 1;
      for (int t = f + 1; t <= b; t++) exp_q.push_back(t);
      for (int j = 1; j <= len; j++) exp_q.push_back(b + j * (d + 1));
      pl = b + len * (d + 1);
      @(negedge clk); burst_start = 1'b0;
      @(negedge clk); burst_start = 1'b1; burst_len = BW'(9);   // second start mid-burst
      @(negedge clk); burst_start = 1'b0;
      while (edge_n < pl + 4) begin
         checks++;
         if (busy !== (edge_n >= b && edge_n <= pl))
            $display("FAIL burst_busy edge %0d: got %b want %b", edge_n, busy, (edge_n >= b && edge_n <= pl));
         else passes++;
         @(negedge clk);
      end
      burst_start = 1'b1; burst_len = '0;                        // zero-length request
      @(negedge clk); burst_start = 1'b0;
      checks++;
      if (state !== 3'd1 || busy !== 1'b0) $display("FAIL burst_len0: state=%0d busy=%b want 1/0", state, busy);
      else passes++;
      @(negedge clk); mode = 2'd0;                               // HALT from edge pl+7
      for (int t = pl + 2; t <= pl + 7; t++) exp_q.push_back(t);
      repeat (4) @(negedge clk);
      checks++;
      if (pulses.size() != exp_q.size())
         $display("FAIL burst_count (d=%0d len=%0d): got %0d pulses want %0d", d, len, pulses.size(), exp_q.size());
      else passes++;
      for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
         checks++;
         if (pulses[i] != exp_q[i]) $display("FAIL burst_pulse%0d: got edge %0d want edge %0d", i, pulses[i], exp_q[i]);
         else passes++;
      end
      exp_cyc += 32'(exp_q.size());
      checks++;
      if (cyc_count !== exp_cyc) $display("FAIL burst_cyc: got %0d want %0d", cyc_count, exp_cyc);
      else passes++;
   endtask

   task automatic test_back_to_back();
      int b, d, len, pl;
      pulses.delete(); exp_q.delete();
      d = $urandom_range(3, 1); len = $urandom_range(5, 1);
      // Mode change and burst request in the same cycle: the burst must win.
      mode = 2'd1; div_max = N'(d); burst_start = 1'b1; burst_len = BW'(len); b = edge_n + 1;
      @(negedge clk); burst_start = 1'b0;
      checks++;
      if (state !== 3'd4 || busy !== 1'b1) $display("FAIL b2b_wins: state=%0d busy=%b want 4/1", state, busy);
      else passes++;
      for (int j = 1; j <= len; j++) exp_q.push_back(b + j * (d + 1));
      pl = b + len * (d + 1);
      wait_edge(pl + 3);
      mode = 2'd0;
      for (int t = pl + 2; t <= pl + 4; t++) exp_q.push_back(t);
      repeat (4) @(negedge clk);
      checks++;
      if (state !== 3'd0) $display("FAIL b2b_state: got %0d want 0", state);
      else passes++;
      checks++;
      if (pulses.size() != exp_q.size())
         $display("FAIL b2b_count (d=%0d len=%0d): got %0d pulses want %0d", d, len, pulses.size(), exp_q.size());
      else passes++;
      for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
         checks++;
         if (pulses[i] != exp_q[i]) $display("FAIL b2b_pulse%0d: got edge %0d want edge %0d", i, pulses[i], exp_q[i]);
         else passes++;
      end
      exp_cyc += 32'(exp_q.size());
   endtask

   task automatic test_reset_mid_burst();
      int b, d;
      pulses.delete(); exp_q.delete();
      d = $urandom_range(3, 1);
      mode = 2'd0; div_max = N'(d); burst_start = 1'b1; burst_len = BW'(5); b = edge_n + 1;
      @(negedge clk); burst_start = 1'b0;
      exp_q = '{b + d + 1, b + 2 * (d + 1)};
      wait_edge(b + 2 * (d + 1));
      #1;
      checks++;
      if (pulses.size() != 2 || pulses[0] != exp_q[0] || pulses[1] != exp_q[1])
         $display("FAIL rstb_pre: got %0d pulses want 2 at edges %0d,%0d", pulses.size(), exp_q[0], exp_q[1]);
      else passes++;
      rst = 1'b1;
      #1;
      checks++;
      if (cpu_en !== 1'b0 || busy !== 1'b0 || state !== 3'd0 || cyc_count !== 32'd0)
         $display("FAIL rstb_async: en=%b busy=%b state=%0d cyc=%0d want 0/0/0/0", cpu_en, busy, state, cyc_count);
      else passes++;
      repeat (2) @(negedge clk);
      pulses.delete();
      rst = 1'b0;
      exp_cyc = 32'd0;
      repeat (6 * (d + 1)) @(negedge clk);
      checks++;
      if (pulses.size() != 0) $display("FAIL rstb_after: got %0d pulses want 0", pulses.size());
      else passes++;
      checks++;
      if (state !== 3'd0 || busy !== 1'b0) $display("FAIL rstb_state: state=%0d busy=%b want 0/0", state, busy);
      else passes++;
   endtask

   task automatic test_free_wrap();
      int f;
      pulses.delete();
      mode = 2'd1; f = edge_n + 1;
      wait_edge(f + 9);
      mode = 2'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (pulses.size() != 10) $display("FAIL free_pulses: got %0d want 10", pulses.size());
      else passes++;
      exp_cyc += 32'd10;
      checks++;
      if (cyc_count !== exp_cyc) $display("FAIL free_cyc: got %0d want %0d", cyc_count, exp_cyc);
      else passes++;
      dut.cyc_cnt = 32'hFFFF_FFFE;
      @(negedge clk);
      mode = 2'd1; f = edge_n + 1;
      wait_edge(f + 1);
      mode = 2'd0;
      wait_edge(f + 2);
      checks++;
      if (cyc_count !== 32'hFFFF_FFFF) $display("FAIL wrap_pre: got %h want ffffffff", cyc_count);
      else passes++;
      @(negedge clk);
      checks++;
      if (cyc_count !== 32'd0) $display("FAIL wrap_zero: got %h want 00000000", cyc_count);
      else passes++;
      repeat (3) @(negedge clk);
      checks++;
      if (cyc_count !== 32'd0) $display("FAIL wrap_hold: got %h want 00000000", cyc_count);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_slow();
      test_step();
      test_burst();
      test_back_to_back();
      test_reset_mid_burst();
      test_free_wrap();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
